// File: rtl/ifetch_tag_stage_if.sv
// ----------------------------------------------------------------------------
// ifetch_tag_stage_if
//
// Valid/ready bundle between the instruction-fetch tag stage and the
// fetch-data/hit stage. The tag stage drives one fetch per transfer: warp
// index, PC, every tag of the addressed L1I set and that set's valid bits.
//
// Signals:
//   ft_valid      tag stage -> data stage   output register holds a fetch
//   ft_ready      data stage -> tag stage   ft_* accepted this cycle
//   ft_warp_idx   tag stage -> data stage   warp of the fetch
//   ft_pc         tag stage -> data stage   PC of the fetch
//   ft_tags       tag stage -> data stage   tags of addressed set, way 0 in LSBs
//   ft_way_valid  tag stage -> data stage   valid bits of addressed set
//
// Modports:
//   master  tag stage side (drives ft_*, samples ft_ready)
//   slave   fetch-data/hit stage side
//
// Parameters must match those of the ifetch_tag_stage instance it connects.
// ----------------------------------------------------------------------------
interface ifetch_tag_stage_if #(
    parameter int unsigned NUM_WARPS  = 4,
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned NUM_SETS   = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_BYTES = 64
);
    localparam int unsigned WIDX_W = $clog2(NUM_WARPS);
    localparam int unsigned SET_W  = $clog2(NUM_SETS);
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned TAG_W  = ADDR_WIDTH - SET_W - OFF_W;

    logic                      ft_valid;
    logic                      ft_ready;
    logic [WIDX_W-1:0]         ft_warp_idx;
    logic [ADDR_WIDTH-1:0]     ft_pc;
    logic [NUM_WAYS*TAG_W-1:0] ft_tags;
    logic [NUM_WAYS-1:0]       ft_way_valid;

    modport master (
        output ft_valid,
        output ft_warp_idx,
        output ft_pc,
        output ft_tags,
        output ft_way_valid,
        input  ft_ready
    );

    modport slave (
        input  ft_valid,
        input  ft_warp_idx,
        input  ft_pc,
        input  ft_tags,
        input  ft_way_valid,
        output ft_ready
    );
endinterface

// File: rtl/ifetch_tag_stage.sv
// ----------------------------------------------------------------------------
// ifetch_tag_stage
//
// Per-SM instruction-fetch tag stage. Holds one PC per warp, round-robin
// arbitrates among eligible warps, reads the L1I tag and valid arrays for the
// granted warp's PC and registers warp, PC, tags and valid bits into a
// valid/ready output register towards the fetch-data/hit stage.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   warp_enable    warp active mask
//   warp_stall     warp blocked (e.g. pending miss); excluded from arbitration
//   redirect_en    load redirect_pc into warp redirect_warp
//   redirect_warp  warp being redirected
//   redirect_pc    new PC
//   fill_en        write fill_tag into [fill_set][fill_way] and set its valid
//   fill_set       set written
//   fill_way       way written
//   fill_tag       tag written
//   inval_all      clear every valid bit (wins over a same-cycle fill)
//   ft             master side of ifetch_tag_stage_if (ft_valid/ft_ready,
//                  ft_warp_idx, ft_pc, ft_tags, ft_way_valid)
//
// Build option:
//   IFT_TAG_BYPASS_EN  when defined, a fill to the set being read in the same
//                      cycle is forwarded into ft_tags/ft_way_valid
//                      (write-first). Undefined: read-first, the fill is only
//                      visible to later reads.
// ----------------------------------------------------------------------------
module ifetch_tag_stage #(
    parameter int unsigned NUM_WARPS  = 4,
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned NUM_SETS   = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned INST_BYTES = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    localparam int unsigned WIDX_W = $clog2(NUM_WARPS),
    localparam int unsigned SET_W  = $clog2(NUM_SETS),
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES),
    localparam int unsigned TAG_W  = ADDR_WIDTH - SET_W - OFF_W,
    localparam int unsigned WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_WARPS-1:0]  warp_enable,
    input  logic [NUM_WARPS-1:0]  warp_stall,
    input  logic                  redirect_en,
    input  logic [WIDX_W-1:0]     redirect_warp,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  fill_en,
    input  logic [SET_W-1:0]      fill_set,
    input  logic [WAY_W-1:0]      fill_way,
    input  logic [TAG_W-1:0]      fill_tag,
    input  logic                  inval_all,
    ifetch_tag_stage_if.master    ft
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]     pc_q [NUM_WARPS];
    logic [ADDR_WIDTH-1:0]     pc_d [NUM_WARPS];
    logic [WIDX_W-1:0]         ptr_q;
    logic [WIDX_W-1:0]         ptr_d;

    // Valid bits are reset; tag storage is plain SRAM with no reset.
    logic [NUM_WAYS-1:0]       valid_q [NUM_SETS];
    logic [TAG_W-1:0]          tag_mem [NUM_SETS][NUM_WAYS];

    logic                      ft_valid_q;
    logic                      ft_valid_d;
    logic [WIDX_W-1:0]         ft_warp_q;
    logic [ADDR_WIDTH-1:0]     ft_pc_q;
    logic [NUM_WAYS*TAG_W-1:0] ft_tags_q;
    logic [NUM_WAYS-1:0]       ft_way_valid_q;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic [NUM_WARPS-1:0]      eligible;
    logic                      grant_found;
    logic [WIDX_W-1:0]         grant_idx;
    logic                      issue;
    logic                      squash;

    // A warp being redirected this cycle must not fetch from its stale PC.
    always_comb begin
        eligible = warp_enable & ~warp_stall;
        if (redirect_en) begin
            eligible[redirect_warp] = 1'b0;
        end
    end

    // Search starts one past the last grant and wraps; NUM_WARPS is a power
    // of two so the index addition wraps for free. The last candidate tried
    // is the pointer itself.
    always_comb begin
        logic [WIDX_W-1:0] cand;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
            cand = ptr_q + WIDX_W'(i);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Issue only when the output register is empty or being emptied.
    assign issue  = grant_found & (~ft_valid_q | ft.ft_ready);
    assign squash = redirect_en & ft_valid_q & (ft_warp_q == redirect_warp);

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = grant_idx;
        end
    end

    // ------------------------------------------------------------------------
    // Per-warp PCs
    // ------------------------------------------------------------------------
    // The granted warp is never the redirected one, so the two updates never
    // collide on the same entry.
    always_comb begin
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            pc_d[w] = pc_q[w];
        end
        if (issue) begin
            pc_d[grant_idx] = pc_q[grant_idx] + ADDR_WIDTH'(INST_BYTES);
        end
        if (redirect_en) begin
            pc_d[redirect_warp] = redirect_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                pc_q[w] <= RESET_PC;
            end
            ptr_q <= WIDX_W'(NUM_WARPS - 1);
        end else begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                pc_q[w] <= pc_d[w];
            end
            ptr_q <= ptr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Tag / valid read path
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]     issue_pc;
    logic [SET_W-1:0]          issue_set;
    logic [NUM_WAYS*TAG_W-1:0] rd_tags;
    logic [NUM_WAYS-1:0]       rd_valid;

    assign issue_pc  = pc_q[grant_idx];
    assign issue_set = issue_pc[SET_W+OFF_W-1:OFF_W];

    always_comb begin
        rd_tags  = '0;
        rd_valid = valid_q[issue_set];
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            rd_tags[w*TAG_W +: TAG_W] = tag_mem[issue_set][w];
        end
`ifdef IFT_TAG_BYPASS_EN
        // Write-first: forward a concurrent fill to the set being read.
        if (fill_en && (fill_set == issue_set)) begin
            rd_valid[fill_way]                       = 1'b1;
            rd_tags[int'(fill_way)*TAG_W +: TAG_W] = fill_tag;
        end
`endif
        // A concurrent invalidate wins over both stored and forwarded bits.
        if (inval_all) begin
            rd_valid = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Tag / valid write path
    // ------------------------------------------------------------------------
    // The tag is written even when inval_all suppresses the valid bit.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_set][fill_way] <= fill_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (inval_all) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (fill_en) begin
            valid_q[fill_set][fill_way] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    // Priority: a new issue replaces the contents; otherwise a handshake or a
    // redirect of the held warp empties it; otherwise everything holds.
    always_comb begin
        ft_valid_d = ft_valid_q;
        if (issue) begin
            ft_valid_d = 1'b1;
        end else if (ft_valid_q && ft.ft_ready) begin
            ft_valid_d = 1'b0;
        end else if (squash) begin
            ft_valid_d = 1'b0;
        end
    end

    // Payload only loads on issue, so it stays stable under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ft_valid_q     <= 1'b0;
            ft_warp_q      <= '0;
            ft_pc_q        <= '0;
            ft_tags_q      <= '0;
            ft_way_valid_q <= '0;
        end else begin
            ft_valid_q <= ft_valid_d;
            if (issue) begin
                ft_warp_q      <= grant_idx;
                ft_pc_q        <= issue_pc;
                ft_tags_q      <= rd_tags;
                ft_way_valid_q <= rd_valid;
            end
        end
    end

    assign ft.ft_valid     = ft_valid_q;
    assign ft.ft_warp_idx  = ft_warp_q;
    assign ft.ft_pc        = ft_pc_q;
    assign ft.ft_tags      = ft_tags_q;
    assign ft.ft_way_valid = ft_way_valid_q;

endmodule

// File: tb/tb_ifetch_tag_stage.sv
// ----------------------------------------------------------------------------
// tb_ifetch_tag_stage
//
// Directed sequences with literal expectations, followed by a randomized run.
// A behavioural model (plain arrays of PCs, tags and valid bits plus the
// expected output register contents) advances once per clock and the DUT
// outputs are compared against it after every edge.
// ----------------------------------------------------------------------------
module tb_ifetch_tag_stage;

    localparam int NW     = 4;
    localparam int NWAYS  = 4;
    localparam int NSETS  = 64;
    localparam int AW     = 32;
    localparam int LB     = 64;
    localparam int IB     = 4;
    localparam int SET_W  = 6;
    localparam int TAG_W  = 20;
    localparam int WIDX_W = 2;
    localparam int WAY_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NW-1:0]     warp_enable;
    logic [NW-1:0]     warp_stall;
    logic              redirect_en;
    logic [WIDX_W-1:0] redirect_warp;
    logic [AW-1:0]     redirect_pc;
    logic              fill_en;
    logic [SET_W-1:0]  fill_set;
    logic [WAY_W-1:0]  fill_way;
    logic [TAG_W-1:0]  fill_tag;
    logic              inval_all;

    ifetch_tag_stage_if #(
        .NUM_WARPS (NW),
        .NUM_WAYS  (NWAYS),
        .NUM_SETS  (NSETS),
        .ADDR_WIDTH(AW),
        .LINE_BYTES(LB)
    ) ft_if ();

    ifetch_tag_stage #(
        .NUM_WARPS (NW),
        .NUM_WAYS  (NWAYS),
        .NUM_SETS  (NSETS),
        .ADDR_WIDTH(AW),
        .LINE_BYTES(LB),
        .INST_BYTES(IB),
        .RESET_PC  ('0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .warp_enable  (warp_enable),
        .warp_stall   (warp_stall),
        .redirect_en  (redirect_en),
        .redirect_warp(redirect_warp),
        .redirect_pc  (redirect_pc),
        .fill_en      (fill_en),
        .fill_set     (fill_set),
        .fill_way     (fill_way),
        .fill_tag     (fill_tag),
        .inval_all    (inval_all),
        .ft           (ft_if.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- behavioural model ----------------
    logic [AW-1:0]    m_pc [NW];
    int               m_ptr;
    bit               m_valid [NSETS][NWAYS];
    logic [TAG_W-1:0] m_tag [NSETS][NWAYS];
    bit               m_fv;
    int               m_fw;
    logic [AW-1:0]    m_fpc;
    logic [TAG_W-1:0] m_ftag [NWAYS];
    bit               m_fwv [NWAYS];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++) m_pc[w] = '0;
        m_ptr = NW - 1;
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < NWAYS; w++) m_valid[s][w] = 1'b0;
        m_fv  = 1'b0;
        m_fw  = 0;
        m_fpc = '0;
        for (int w = 0; w < NWAYS; w++) begin
            m_ftag[w] = '0;
            m_fwv[w]  = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit               elig [NW];
        bit               found;
        bit               iss;
        int               g;
        int               s;
        bit               rv [NWAYS];
        logic [TAG_W-1:0] rt [NWAYS];
        if (reset) begin
            model_reset();
            return;
        end
        for (int w = 0; w < NW; w++)
            elig[w] = warp_enable[w] && !warp_stall[w] &&
                      !(redirect_en && int'(redirect_warp) == w);
        found = 1'b0;
        g = 0;
        for (int k = 1; k <= NW; k++) begin
            int c;
            c = (m_ptr + k) % NW;
            if (!found && elig[c]) begin
                found = 1'b1;
                g = c;
            end
        end
        iss = found && (!m_fv || ft_if.ft_ready);
        if (iss) begin
            s = int'((m_pc[g] / LB) % NSETS);
            for (int w = 0; w < NWAYS; w++) begin
                rv[w] = m_valid[s][w];
                rt[w] = m_tag[s][w];
            end
`ifdef IFT_TAG_BYPASS_EN
            if (fill_en && int'(fill_set) == s) begin
                rv[fill_way] = 1'b1;
                rt[fill_way] = fill_tag;
            end
`endif
            if (inval_all)
                for (int w = 0; w < NWAYS; w++) rv[w] = 1'b0;
            m_fv  = 1'b1;
            m_fw  = g;
            m_fpc = m_pc[g];
            for (int w = 0; w < NWAYS; w++) begin
                m_ftag[w] = rt[w];
                m_fwv[w]  = rv[w];
            end
            m_pc[g] = m_pc[g] + IB;
            m_ptr   = g;
        end else if (m_fv && ft_if.ft_ready) begin
            m_fv = 1'b0;
        end else if (m_fv && redirect_en && int'(redirect_warp) == m_fw) begin
            m_fv = 1'b0;
        end
        if (redirect_en) m_pc[redirect_warp] = redirect_pc;
        if (fill_en) m_tag[fill_set][fill_way] = fill_tag;
        if (inval_all) begin
            for (int ss = 0; ss < NSETS; ss++)
                for (int w = 0; w < NWAYS; w++) m_valid[ss][w] = 1'b0;
        end else if (fill_en) begin
            m_valid[fill_set][fill_way] = 1'b1;
        end
    endtask

    task automatic compare_model();
        logic [NWAYS-1:0] ev;
        chk("model ft_valid", ft_if.ft_valid, m_fv);
        if (m_fv) begin
            for (int w = 0; w < NWAYS; w++) ev[w] = m_fwv[w];
            chk("model ft_warp_idx", ft_if.ft_warp_idx, m_fw);
            chk("model ft_pc", ft_if.ft_pc, m_fpc);
            chk("model ft_way_valid", ft_if.ft_way_valid, ev);
            // Tags of invalid ways are unspecified.
            for (int w = 0; w < NWAYS; w++)
                if (m_fwv[w]) chk("model ft_tags", ft_if.ft_tags[w*TAG_W +: TAG_W], m_ftag[w]);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle();
        redirect_en   = 1'b0;
        redirect_warp = '0;
        redirect_pc   = '0;
        fill_en       = 1'b0;
        fill_set      = '0;
        fill_way      = '0;
        fill_tag      = '0;
        inval_all     = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ft_valid"}, ft_if.ft_valid, 0);
        chk({tag, " ft_warp_idx"}, ft_if.ft_warp_idx, 0);
        chk({tag, " ft_pc"}, ft_if.ft_pc, 0);
        chk({tag, " ft_tags"}, ft_if.ft_tags, 0);
        chk({tag, " ft_way_valid"}, ft_if.ft_way_valid, 0);
    endtask

    initial begin
        logic [WIDX_W-1:0] t3_order [6];
        t3_order[0] = 2'd3; t3_order[1] = 2'd0; t3_order[2] = 2'd1;
        t3_order[3] = 2'd3; t3_order[4] = 2'd0; t3_order[5] = 2'd1;

        reset          = 1'b1;
        warp_enable    = '0;
        warp_stall     = '0;
        ft_if.ft_ready = 1'b1;
        idle();
        model_reset();
        #1;
        chk_reset_outputs("reset");
        cycle();
        cycle();

        // Round robin from reset, all warps eligible.
        reset       = 1'b0;
        warp_enable = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr warp", ft_if.ft_warp_idx, i % 4);
            chk("rr pc", ft_if.ft_pc, (i < 4) ? 0 : 4);
            chk("rr way_valid", ft_if.ft_way_valid, 0);
        end

        // Backpressure on warp 1.
        cycle();
        chk("bp warp", ft_if.ft_warp_idx, 1);
        ft_if.ft_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp hold valid", ft_if.ft_valid, 1);
            chk("bp hold warp", ft_if.ft_warp_idx, 1);
            chk("bp hold pc", ft_if.ft_pc, 4);
        end
        ft_if.ft_ready = 1'b1;
        cycle();
        chk("bp next warp", ft_if.ft_warp_idx, 2);
        chk("bp next pc", ft_if.ft_pc, 4);

        // Stall mask on warp 2.
        warp_stall = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("stall order", ft_if.ft_warp_idx, t3_order[i]);
        end
        warp_stall = '0;
        cycle();
        chk("stall release warp", ft_if.ft_warp_idx, 2);
        chk("stall release pc", ft_if.ft_pc, 8);

        // Fill then hit.
        warp_enable = '0;
        fill_en = 1'b1; fill_set = 6'd5; fill_way = 2'd2; fill_tag = 20'h01234;
        cycle();
        idle();
        redirect_en = 1'b1; redirect_warp = 2'd0; redirect_pc = 32'h140;
        cycle();
        idle();
        warp_enable = 4'b0001;
        cycle();
        chk("fill pc", ft_if.ft_pc, 32'h140);
        chk("fill way_valid", ft_if.ft_way_valid, 4'b0100);
        chk("fill tag", ft_if.ft_tags[2*TAG_W +: TAG_W], 20'h01234);

        // Fill with concurrent invalidate.
        warp_enable = '0;
        fill_en = 1'b1; fill_set = 6'd5; fill_way = 2'd1; fill_tag = 20'h05678;
        inval_all = 1'b1;
        cycle();
        idle();
        redirect_en = 1'b1; redirect_warp = 2'd0; redirect_pc = 32'h140;
        cycle();
        idle();
        warp_enable = 4'b0001;
        cycle();
        chk("inval way_valid", ft_if.ft_way_valid, 4'b0000);

        // Redirect squashes the held fetch of the same warp.
        warp_enable = 4'b1000;
        cycle();
        chk("squash pre warp", ft_if.ft_warp_idx, 3);
        ft_if.ft_ready = 1'b0;
        redirect_en = 1'b1; redirect_warp = 2'd3; redirect_pc = 32'h8000;
        cycle();
        chk("squash valid", ft_if.ft_valid, 0);
        idle();
        ft_if.ft_ready = 1'b1;
        cycle();
        chk("squash refetch warp", ft_if.ft_warp_idx, 3);
        chk("squash refetch pc", ft_if.ft_pc, 32'h8000);

        // Fill to the set being read in the same cycle.
        warp_enable = '0;
        redirect_en = 1'b1; redirect_warp = 2'd0; redirect_pc = 32'h380;
        cycle();
        idle();
        warp_enable = 4'b0001;
        fill_en = 1'b1; fill_set = 6'd14; fill_way = 2'd3; fill_tag = 20'h00abc;
        cycle();
`ifdef IFT_TAG_BYPASS_EN
        chk("bypass way_valid", ft_if.ft_way_valid, 4'b1000);
        chk("bypass tag", ft_if.ft_tags[3*TAG_W +: TAG_W], 20'h00abc);
`else
        chk("bypass way_valid", ft_if.ft_way_valid, 4'b0000);
`endif
        idle();
        cycle();
        chk("post-fill pc", ft_if.ft_pc, 32'h384);
        chk("post-fill way_valid", ft_if.ft_way_valid, 4'b1000);

        // PC wrap.
        warp_enable = '0;
        redirect_en = 1'b1; redirect_warp = 2'd1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        idle();
        warp_enable = 4'b0010;
        cycle();
        chk("wrap pc0", ft_if.ft_pc, 32'hFFFF_FFFC);
        cycle();
        chk("wrap pc1", ft_if.ft_pc, 32'h0);

        // Asynchronous reset while stalled.
        warp_enable    = 4'b1111;
        ft_if.ft_ready = 1'b0;
        cycle();
        cycle();
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async reset");
        cycle();
        reset          = 1'b0;
        ft_if.ft_ready = 1'b1;

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 599) == 0);
            warp_enable    = NW'($urandom);
            warp_stall     = ($urandom_range(0, 3) == 0) ? NW'($urandom) : '0;
            ft_if.ft_ready = ($urandom_range(0, 3) != 0);
            redirect_en    = ($urandom_range(0, 7) == 0);
            redirect_warp  = WIDX_W'($urandom);
            if ($urandom_range(0, 9) == 0)
                redirect_pc = 32'hFFFF_FFF0 | AW'($urandom_range(0, 3) * 4);
            else
                redirect_pc = AW'($urandom_range(0, 127) * 4);
            fill_en   = ($urandom_range(0, 2) == 0);
            fill_set  = SET_W'($urandom_range(0, 7));
            fill_way  = WAY_W'($urandom);
            fill_tag  = TAG_W'($urandom);
            inval_all = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
